// File: rtl/aes_inv_sub_addkey_if.sv
// aes_inv_sub_addkey_if: valid/ready handshake bundle for the inverse sub/addkey stage
interface aes_inv_sub_addkey_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;
  modport master (output in_valid, state_in, round_key, out_ready,
                  input  in_ready, out_valid, state_out, busy);
  modport slave  (input  in_valid, state_in, round_key, out_ready,
                  output in_ready, out_valid, state_out, busy);
endinterface

// File: rtl/aes_inv_sub_addkey.sv
// aes_inv_sub_addkey: InvShiftRows -> byte-serial InvSubBytes -> AddRoundKey
module aes_inv_sub_addkey #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst_n,
  aes_inv_sub_addkey_if.slave io
);
  localparam int NG = 16 / BYTES_PER_CYCLE;
  localparam int CW = NG > 1 ? $clog2(NG) : 1;
  typedef enum logic [1:0] {IDLE, SUB, OUT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt;
  logic [0:15][7:0] work, key, subbed;
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(logic [7:0] x);
    logic [7:0] sq, r;
    sq = gf_mul(x, x);
    r  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction
  function automatic logic [7:0] inv_sbox(logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction
  // row r rotates right by r: out[r][c] = in[r][(c-r) mod 4]
  function automatic logic [0:15][7:0] inv_shift_rows(logic [0:15][7:0] s);
    logic [0:15][7:0] r;
    for (int b = 0; b < 16; b++)
      r[b] = s[b % 4 + 4 * (((b / 4) - (b % 4) + 4) % 4)];
    return r;
  endfunction
  assign io.in_ready  = state_q == IDLE;
  assign io.busy      = state_q != IDLE;
  assign io.out_valid = state_q == OUT;
  assign io.state_out = work;
  // current lane group substituted and keyed, other bytes untouched
  always_comb begin
    subbed = work;
    for (int k = 0; k < BYTES_PER_CYCLE; k++)
      subbed[4'(int'(cnt) * BYTES_PER_CYCLE + k)] =
        inv_sbox(work[4'(int'(cnt) * BYTES_PER_CYCLE + k)]) ^ key[4'(int'(cnt) * BYTES_PER_CYCLE + k)];
  end
  // next state: accept in IDLE, leave SUB after last group, leave OUT on out_ready
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (io.in_valid ? SUB : IDLE) :
              state_q == SUB  ? (cnt == CW'(NG - 1) ? OUT : SUB) :
              (io.out_ready ? IDLE : OUT);
  end
  // state, counter and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt     <= '0;
      work    <= '0;
      key     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && io.in_valid) begin
        work <= inv_shift_rows(io.state_in);
        key  <= io.round_key;
        cnt  <= '0;
      end else if (state_q == SUB) begin
        work <= subbed;
        cnt  <= state_d == OUT ? '0 : cnt + 1'b1;
      end
    end
  end
endmodule
